keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x3 membrane keypad (rows driven, columns sensed), debounces one key press, and
//  emits a single-cycle valid pulse with a 4-bit key code. Sits directly upstream of
//  button_controller and drives its valid/code inputs. Emits one pulse per press, none on release.
// PARAMETERS
//  CLK_DIV       1000  clock cycles per scan tick (>=2); row advance and debounce sampling rate
//  DEBOUNCE_CNT  4     consecutive stable scan ticks required for press and for release (>=1)
// PORTS
//  clock    in   1  system clock; all logic on rising edge
//  reset_n  in   1  reset, asynchronous, active-low
//  col_in   in   3  keypad columns, active-low (pulled up externally), asynchronous to clock
//  row_out  out  4  keypad row drive, active-low one-cold: exactly one bit 0 at all times
//  valid    out  1  one-cycle pulse: code holds a new key
//  code     out  4  key code; 0-9 digits, 0xA '*', 0xB '#'; held until next valid
// BEHAVIOUR
//  - Reset (reset_n=0, immediate): row_out=4'b1110, valid=0, code=0, state=SCAN, all counters 0.
//    Reset mid-debounce discards the pending key; no valid is produced for it.
//  - col_in passes through a 2-flop synchronizer before any use (2 cycles sense latency).
//  - Tick counter counts 0..CLK_DIV-1, wraps to 0; tick=1 for the cycle it equals CLK_DIV-1.
//  - Key map row r (0..3), col c (0..2): r0: 1,2,3  r1: 4,5,6  r2: 7,8,9  r3: *,0,#.
//  - Several columns low at once: lowest c wins. Only the currently driven row is sensed.
//  FSM (transitions evaluated only on tick, except EMIT):
//   SCAN:     any synced col low -> latch row/col, deb_cnt=1, DEBOUNCE (row held);
//             else rotate row_out left (1110->1101->1011->0111->1110).
//   DEBOUNCE: same col still low -> deb_cnt++; on deb_cnt==DEBOUNCE_CNT -> EMIT.
//             col pattern changed or released -> SCAN (no output, row advances next tick).
//   EMIT:     one clock cycle: code<=mapped key, valid=1 (or suppressed, see CONFIGURATION);
//             -> RELEASE next cycle unconditionally.
//   RELEASE:  row held; all cols high -> rel_cnt++, any low -> rel_cnt=0;
//             rel_cnt==DEBOUNCE_CNT -> SCAN. Held key never re-emits (no autorepeat).
//  - valid is high for exactly one cycle per press; min spacing between pulses is
//    2*DEBOUNCE_CNT ticks, so button_controller never sees back-to-back valids.
//  - Press latency: first stable tick + (DEBOUNCE_CNT-1) ticks + 1 cycle.
//  - Counters sized $clog2 of their maximum; tick and debounce counters never overflow
//    (compare-and-clear, not free-running wrap).
// CONFIGURATION
//  KEYPAD_FUNC_KEYS_EN
//   defined:     '*' and '#' produce valid with code 0xA / 0xB.
//   not defined: '*' and '#' are debounced and released normally but produce no valid and
//                leave code unchanged; only digits 0-9 reach button_controller.
// STRUCTURE
//  - Package keypad_pkg: scan state enum (SCAN, DEBOUNCE, EMIT, RELEASE, 2-bit),
//    KEY_STAR=4'hA, KEY_HASH=4'hB, NUM_ROWS=4, NUM_COLS=3, key-map lookup function.
//  - One sub-module: keypad_sync (2-flop synchronizer, width parameter, async active-low reset,
//    reset value all-ones) for col_in. FSM, tick and debounce counters live in keypad_scanner.
// TESTING (bench uses CLK_DIV=4, DEBOUNCE_CNT=3)
//  1 Reset: reset_n low mid-run -> row_out=1110, valid=0, code=0 same cycle; rows rotate after release.
//  2 Press '5' (col1 low while row_out=1101) held 20 ticks -> exactly one valid, code=5;
//    none on release.
//  3 Bounce: col0 low 2 ticks, high 1, low 4 ticks on row0 -> single valid code=1, after 2nd run.
//  4 '7' and '9' pressed together on row2 -> code=7 (lowest column wins).
//  5 Sequence '4' then '2', each released 4 ticks -> two pulses code=4, code=2; downstream
//    button_controller reports product_no=42.
//  6 '#' pressed: with KEYPAD_FUNC_KEYS_EN -> valid, code=0xB; without -> no valid, code unchanged.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants and key-map helpers for the 4x3 keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    typedef logic [1:0] scan_state_t;
    localparam scan_state_t ST_SCAN     = 2'd0;
    localparam scan_state_t ST_DEBOUNCE = 2'd1;
    localparam scan_state_t ST_EMIT     = 2'd2;
    localparam scan_state_t ST_RELEASE  = 2'd3;

    // Key code for a row/column position; row 3 carries '*', '0', '#'.
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] key;
        key = 4'h0;
        if (row == 2'd3) begin
            case (col)
                2'd0:    key = KEY_STAR;
                2'd1:    key = 4'h0;
                2'd2:    key = KEY_HASH;
                default: key = 4'h0;
            endcase
        end else begin
            key = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
        end
        return key;
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] row_n);
        logic [1:0] idx;
        case (row_n)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Lowest active-low column wins when several are pressed together.
    function automatic logic [1:0] first_low_col(input logic [2:0] col_n);
        logic [1:0] idx;
        if (!col_n[0]) begin
            idx = 2'd0;
        end else if (!col_n[1]) begin
            idx = 2'd1;
        end else if (!col_n[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer; idles at all-ones to match pulled-up keypad columns.
module keypad_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // Metastability filter chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= {WIDTH{1'b1}};
            sync_r <= {WIDTH{1'b1}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner with debounce; one valid pulse per press.
// Define KEYPAD_FUNC_KEYS_EN to let '*' and '#' produce valid pulses.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV      = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] col_in,
    output logic [3:0] row_out,
    output logic       valid,
    output logic [3:0] code
);

    localparam int TICK_W = $clog2(CLK_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT);
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);

    logic [NUM_COLS-1:0] col_sync_s;
    logic [TICK_W-1:0]   tick_cnt_r;
    logic                tick_s;
    scan_state_t         state_r, state_nxt_s;
    logic [NUM_ROWS-1:0] row_r, row_nxt_s;
    logic [DEB_W-1:0]    deb_cnt_r, deb_nxt_s;
    logic [DEB_W-1:0]    rel_cnt_r, rel_nxt_s;
    logic [2:0]          col_pat_r, col_pat_nxt_s;
    logic [1:0]          col_idx_r, col_idx_nxt_s;
    logic                valid_r, valid_nxt_s;
    logic [3:0]          code_r, code_nxt_s;
    logic [3:0]          key_s;
    logic                func_ok_s;
    logic                emit_ok_s;

    keypad_sync #(.WIDTH(NUM_COLS)) u_col_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (col_in),
        .q       (col_sync_s)
    );

`ifdef KEYPAD_FUNC_KEYS_EN
    assign func_ok_s = 1'b1;
`else
    assign func_ok_s = 1'b0;
`endif

    assign tick_s    = (tick_cnt_r == TICK_LAST);
    assign key_s     = key_map(row_index(row_r), col_idx_r);
    assign emit_ok_s = (key_s < KEY_STAR) | func_ok_s;

    // Scan tick divider, cleared on compare so it never wraps through overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else if (tick_s) begin
            tick_cnt_r <= {TICK_W{1'b0}};
        end else begin
            tick_cnt_r <= tick_cnt_r + TICK_W'(1);
        end
    end

    // Scan / debounce / emit / release next-state and output logic.
    always_comb begin
        state_nxt_s   = state_r;
        row_nxt_s     = row_r;
        deb_nxt_s     = deb_cnt_r;
        rel_nxt_s     = rel_cnt_r;
        col_pat_nxt_s = col_pat_r;
        col_idx_nxt_s = col_idx_r;
        valid_nxt_s   = 1'b0;
        code_nxt_s    = code_r;
        case (state_r)
            ST_SCAN: begin
                if (tick_s && (col_sync_s != 3'b111)) begin
                    col_pat_nxt_s = col_sync_s;
                    col_idx_nxt_s = first_low_col(col_sync_s);
                    deb_nxt_s     = DEB_ONE;
                    if (DEB_LAST == DEB_ONE) begin
                        state_nxt_s = ST_EMIT;
                    end else begin
                        state_nxt_s = ST_DEBOUNCE;
                    end
                end else if (tick_s) begin
                    row_nxt_s = {row_r[2:0], row_r[3]};
                end else begin
                    state_nxt_s = ST_SCAN;
                end
            end
            ST_DEBOUNCE: begin
                if (tick_s && (col_sync_s == col_pat_r)) begin
                    deb_nxt_s = deb_cnt_r + DEB_ONE;
                    if ((deb_cnt_r + DEB_ONE) == DEB_LAST) begin
                        state_nxt_s = ST_EMIT;
                    end else begin
                        state_nxt_s = ST_DEBOUNCE;
                    end
                end else if (tick_s) begin
                    deb_nxt_s   = {DEB_W{1'b0}};
                    state_nxt_s = ST_SCAN;
                end else begin
                    state_nxt_s = ST_DEBOUNCE;
                end
            end
            ST_EMIT: begin
                deb_nxt_s   = {DEB_W{1'b0}};
                rel_nxt_s   = {DEB_W{1'b0}};
                state_nxt_s = ST_RELEASE;
                if (emit_ok_s) begin
                    valid_nxt_s = 1'b1;
                    code_nxt_s  = key_s;
                end else begin
                    valid_nxt_s = 1'b0;
                end
            end
            ST_RELEASE: begin
                if (tick_s && (col_sync_s == 3'b111)) begin
                    if ((rel_cnt_r + DEB_ONE) == DEB_LAST) begin
                        rel_nxt_s   = {DEB_W{1'b0}};
                        state_nxt_s = ST_SCAN;
                    end else begin
                        rel_nxt_s = rel_cnt_r + DEB_ONE;
                    end
                end else if (tick_s) begin
                    rel_nxt_s = {DEB_W{1'b0}};
                end else begin
                    state_nxt_s = ST_RELEASE;
                end
            end
            default: begin
                state_nxt_s = ST_SCAN;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_SCAN;
            row_r     <= 4'b1110;
            deb_cnt_r <= {DEB_W{1'b0}};
            rel_cnt_r <= {DEB_W{1'b0}};
            col_pat_r <= 3'b111;
            col_idx_r <= 2'd0;
            valid_r   <= 1'b0;
            code_r    <= 4'h0;
        end else begin
            state_r   <= state_nxt_s;
            row_r     <= row_nxt_s;
            deb_cnt_r <= deb_nxt_s;
            rel_cnt_r <= rel_nxt_s;
            col_pat_r <= col_pat_nxt_s;
            col_idx_r <= col_idx_nxt_s;
            valid_r   <= valid_nxt_s;
            code_r    <= code_nxt_s;
        end
    end

    assign row_out = row_r;
    assign valid   = valid_r;
    assign code    = code_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized scoreboard bench for keypad_scanner (CLK_DIV=4, DEBOUNCE_CNT=3).
module tb_keypad_scanner;

    localparam int CLK_DIV = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] col_in;
    logic [3:0] row_out;
    logic       valid;
    logic [3:0] code;

    logic [3:0][2:0] pressed = '0;

    int         compared = 0;
    int         mismatched = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_code = 4'h0;
    logic       prev_valid = 1'b0;
    int         product_no = 0;
    bit         track_product = 1'b0;

    keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE_CNT(3)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .col_in  (col_in),
        .row_out (row_out),
        .valid   (valid),
        .code    (code)
    );

    always #5 clock = ~clock;

    // Physical keypad: a pressed key shorts its column to the driven (low) row.
    always_comb begin
        col_in = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!row_out[r] && pressed[r][c]) col_in[c] = 1'b0;
            end
        end
    end

    function automatic logic [3:0] model_key(int r, int c);
        if (r < 3) return 4'(r * 3 + c + 1);
        if (c == 0) return 4'hA;
        if (c == 1) return 4'h0;
        return 4'hB;
    endfunction

    function automatic bit emits(logic [3:0] k);
`ifdef KEYPAD_FUNC_KEYS_EN
        return 1'b1;
`else
        return k < 4'hA;
`endif
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every valid pulse, checks held outputs otherwise.
    always @(negedge clock) begin
        if (!reset_n) begin
            exp_code   = 4'h0;
            prev_valid = 1'b0;
        end else begin
            check("row_onecold", (row_out == 4'b1110 || row_out == 4'b1101 ||
                                  row_out == 4'b1011 || row_out == 4'b0111), 1);
            if (valid) begin
                check("valid_single_cycle", prev_valid, 0);
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_valid: got code %0h expected no valid at %0t", code, $time);
                end else begin
                    logic [3:0] e;
                    e = exp_q.pop_front();
                    check("code", code, e);
                    exp_code = e;
                    if (track_product) product_no = product_no * 10 + int'(code);
                end
            end else begin
                check("code_held", code, exp_code);
            end
            prev_valid = valid;
        end
    end

    task automatic wait_ticks(int n);
        repeat (n * CLK_DIV) @(posedge clock);
        #2;
    endtask

    // Press a set of keys on one row, hold, release, then require the queue drained.
    task automatic press_mask(int r, logic [2:0] mask, int hold, int rel);
        int         c0;
        logic [3:0] k;
        c0 = 0;
        for (int c = 2; c >= 0; c--) if (mask[c]) c0 = c;
        k = model_key(r, c0);
        if (emits(k)) exp_q.push_back(k);
        pressed[r] = mask;
        wait_ticks(hold);
        pressed = '0;
        wait_ticks(rel);
        check("drained_after_press", exp_q.size(), 0);
    endtask

    // Leave the caller just after the edge on which row 0 becomes driven.
    task automatic align_row0();
        int n;
        n = 0;
        while (row_out != 4'b0111 && n < 64) begin @(posedge clock); #1; n++; end
        while (row_out != 4'b1110 && n < 64) begin @(posedge clock); #1; n++; end
        check("align_row0", (n < 64), 1);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clock);
        #2;
        check("reset_row", row_out, 4'b1110);
        check("reset_valid", valid, 0);
        check("reset_code", code, 0);
        reset_n = 1'b1;
        wait_ticks(2);

        // '5' held 20 ticks
        press_mask(1, 3'b010, 20, 6);
        // '7' and '9' together: lowest column wins
        press_mask(2, 3'b101, 15, 6);
        // '4' then '2' feeding a digit accumulator
        track_product = 1'b1;
        product_no = 0;
        press_mask(1, 3'b001, 14, 4);
        press_mask(0, 3'b010, 14, 4);
        track_product = 1'b0;
        check("product_no", product_no, 42);
        wait_ticks(4);
        // '#'
        press_mask(3, 3'b100, 15, 6);

        // Bounce on '1': low 2 ticks, high 1, low 4
        align_row0();
        exp_q.push_back(4'h1);
        pressed[0] = 3'b001;
        repeat (2 * CLK_DIV) @(posedge clock);
        #1 pressed = '0;
        repeat (CLK_DIV) @(posedge clock);
        #1 pressed[0] = 3'b001;
        repeat (4 * CLK_DIV) @(posedge clock);
        #1 pressed = '0;
        wait_ticks(6);
        check("bounce_single", exp_q.size(), 0);

        // Reset mid-debounce discards the pending '1'
        press_mask(2, 3'b010, 14, 6);
        align_row0();
        pressed[0] = 3'b001;
        repeat (6) @(posedge clock);
        #1 reset_n = 1'b0;
        #1;
        check("midreset_row", row_out, 4'b1110);
        check("midreset_valid", valid, 0);
        check("midreset_code", code, 0);
        pressed = '0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;
        n = 0;
        while (row_out == 4'b1110 && n < 40) begin @(posedge clock); #1; n++; end
        check("rotate_after_reset", row_out, 4'b1101);
        wait_ticks(8);
        check("no_valid_after_reset", exp_q.size(), 0);

        // Randomized presses with occasional single-tick glitches
        for (int i = 0; i < 16; i++) begin
            int r;
            if ($urandom_range(0, 1) == 1) begin
                pressed[$urandom_range(0, 3)] = 3'($urandom_range(1, 7));
                wait_ticks(1);
                pressed = '0;
                wait_ticks(2);
            end
            r = $urandom_range(0, 3);
            press_mask(r, 3'($urandom_range(1, 7)), $urandom_range(12, 24), $urandom_range(5, 9));
        end

        wait_ticks(4);
        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
